// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI transfer engine
// among NREQ requesters, with launch strobe, completion detect and timeout.
module spi_xfer_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int GO_CYCLES = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [DW-1:0]        rdata,
  output logic                 go_transfer,
  output logic [DW-1:0]        data_write_to_spi,
  input  logic                 data_pack_ready,
  input  logic [DW-1:0]        data_read_from_spi
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cf_q, cf_d;
  logic            s1, s2, s3;
  logic            cmpl;
  logic [NREQ-1:0] gnt_d, done_d;
  logic            err_d, go_d;
  logic [DW-1:0]   rdata_d, wdata_d;
  logic            found;
  logic [IW-1:0]   win;
  logic [DW-1:0]   words [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = req_wdata[i*DW +: DW];
  end

  // falling edge of the SPI-domain ready after a 2-flop synchronizer
  assign cmpl = s3 & ~s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= data_pack_ready;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    found = 1'b0;
    win   = '0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last_q) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cf_d    = cf_q;
    gnt_d   = gnt;
    go_d    = go_transfer;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata;
    wdata_d = data_write_to_spi;
    if (!en) begin
      state_d = S_IDLE;
      gnt_d   = '0;
      go_d    = 1'b0;
      cf_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (found) begin
            state_d = S_LAUNCH;
            gnt_d   = ONE << win;
            wdata_d = words[win];
            go_d    = 1'b1;
            cnt_d   = '0;
            last_d  = win;
            idx_d   = win;
          end
        end
        S_LAUNCH: begin
          cnt_d = cnt_q + 1'b1;
          if (cmpl) cf_d = 1'b1;
          if (cnt_q == CW'(GO_CYCLES - 1)) begin
            go_d    = 1'b0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          if (cmpl || cf_q) begin
            state_d = S_DONE;
            done_d  = ONE << idx_q;
            rdata_d = data_read_from_spi;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = S_DONE;
            done_d  = ONE << idx_q;
            err_d   = 1'b1;
          end
        end
        S_DONE: begin
          gnt_d   = '0;
          cf_d    = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      last_q            <= IW'(NREQ - 1);
      idx_q             <= '0;
      cnt_q             <= '0;
      cf_q              <= 1'b0;
      gnt               <= '0;
      done              <= '0;
      err               <= 1'b0;
      rdata             <= '0;
      go_transfer       <= 1'b0;
      data_write_to_spi <= '0;
    end else begin
      state_q           <= state_d;
      last_q            <= last_d;
      idx_q             <= idx_d;
      cnt_q             <= cnt_d;
      cf_q              <= cf_d;
      gnt               <= gnt_d;
      done              <= done_d;
      err               <= err_d;
      rdata             <= rdata_d;
      go_transfer       <= go_d;
      data_write_to_spi <= wdata_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed vector table plus hand sequences
// for abort and asynchronous reset.
module tb_spi_xfer_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int GOC  = 4;
  localparam int TO   = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [DW-1:0]     rdata;
  logic              go_transfer;
  logic [DW-1:0]     data_write_to_spi;
  logic              data_pack_ready;
  logic [DW-1:0]     data_read_from_spi;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_xfer_arbiter #(
    .NREQ(NREQ), .DW(DW), .GO_CYCLES(GOC), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .req(req),
    .req_wdata(req_wdata),
    .gnt(gnt),
    .done(done),
    .err(err),
    .rdata(rdata),
    .go_transfer(go_transfer),
    .data_write_to_spi(data_write_to_spi),
    .data_pack_ready(data_pack_ready),
    .data_read_from_spi(data_read_from_spi)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] rd;
    int          dly;
    int          idx;
    logic        err;
    logic [31:0] rdata;
    int          t_done;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic xfer(input vec_t x);
    int w;
    int go_n;
    int t_done;
    bit seen;
    req = x.req;
    data_read_from_spi = x.rd;
    seen = 0;
    w = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      w = k;
      if (go_transfer) begin
        seen = 1;
        break;
      end
    end
    check("launch_latency", seen ? 64'(w) : 64'd99, 64'd1);
    check("gnt_at_launch", 64'(gnt), 64'(oh(x.idx)));
    check("wdata", 64'(data_write_to_spi), 64'(word(x.idx)));
    go_n = 0;
    t_done = -1;
    for (int t = 0; t < 200; t++) begin
      if (t > 0) @(negedge clk);
      if (done != 0) begin
        t_done = t;
        break;
      end
      if (go_transfer) go_n++;
      if (t == x.dly) data_pack_ready = 1'b0;
    end
    check("done_cycle", 64'(t_done), 64'(x.t_done));
    check("done_idx", 64'(done), 64'(oh(x.idx)));
    check("gnt_at_done", 64'(gnt), 64'(oh(x.idx)));
    check("err", 64'(err), 64'(x.err));
    check("rdata", 64'(rdata), 64'(x.rdata));
    check("go_width", 64'(go_n), 64'(GOC));
    @(negedge clk);
    check("done_pulse_end", 64'({done, err}), 64'd0);
    check("gnt_cleared", 64'(gnt), 64'd0);
    data_pack_ready = 1'b1;
  endtask

  initial begin
    int w;
    bit seen;
    bit any_done;

    tbl[0] = '{4'hF, 32'h1111_0000, 20, 0, 1'b0, 32'h1111_0000, 23};
    tbl[1] = '{4'hF, 32'h2222_0000,  8, 1, 1'b0, 32'h2222_0000, 11};
    tbl[2] = '{4'hF, 32'h3333_0000,  2, 2, 1'b0, 32'h3333_0000,  5};
    tbl[3] = '{4'hF, 32'h4444_0000, 30, 3, 1'b0, 32'h4444_0000, 33};
    tbl[4] = '{4'hF, 32'h5555_0000,  5, 0, 1'b0, 32'h5555_0000,  8};
    tbl[5] = '{4'h2, 32'h1234_5678, 20, 1, 1'b0, 32'h1234_5678, 23};
    tbl[6] = '{4'h4, 32'h0BAD_F00D,  1, 2, 1'b0, 32'h0BAD_F00D,  5};
    tbl[7] = '{4'h8, 32'hDEAD_BEEF, -1, 3, 1'b1, 32'h0BAD_F00D, 64};
    tbl[8] = '{4'h9, 32'hCAFE_0009, 10, 0, 1'b0, 32'hCAFE_0009, 13};

    reset_n = 1'b0;
    en = 1'b1;
    req = '0;
    data_pack_ready = 1'b1;
    data_read_from_spi = '0;
    for (int i = 0; i < NREQ; i++) req_wdata[i*DW +: DW] = word(i);
    repeat (3) @(negedge clk);
    check("rst_outputs",
          64'({gnt, done, err, go_transfer}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_wdata", 64'(data_write_to_spi), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) xfer(tbl[i]);

    // abort from WAIT by dropping en
    req = 4'b0010;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (go_transfer) begin
        seen = 1;
        break;
      end
    end
    check("abort_launch", 64'(seen), 64'd1);
    check("abort_gnt", 64'(gnt), 64'(oh(1)));
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!go_transfer) begin
        seen = 1;
        break;
      end
    end
    check("abort_in_wait", 64'(seen), 64'd1);
    en = 1'b0;
    req = '0;
    @(negedge clk);
    check("abort_state",
          64'({gnt, done, err, go_transfer}), 64'd0);
    any_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done != 0 || gnt != 0) any_done = 1;
    end
    check("abort_quiet", 64'(any_done), 64'd0);
    en = 1'b1;
    xfer('{4'h1, 32'h7777_0001, 3, 0, 1'b0, 32'h7777_0001, 6});

    // asynchronous reset in the middle of LAUNCH
    req = 4'b0100;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (go_transfer) begin
        seen = 1;
        break;
      end
    end
    check("rst_launch", 64'(seen), 64'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async",
          64'({gnt, done, err, go_transfer}), 64'd0);
    check("rst_async_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    xfer('{4'h9, 32'h8888_0000, 4, 0, 1'b0, 32'h8888_0000, 7});

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
